icape2_responder: RTL and testbench

- Synthesizable responder for the ICAPE2 side of the 7-series configuration port.
- Accepts the same word stream a Wishbone-to-ICAP bridge drives: dummy, sync, NOOP, Type1/Type2 read and write packets, DESYNC.
- Holds a 32x32 configuration register file and returns readback on the output bus.
- Used in simulation and hardware loopback to check the bridge without real reconfiguration; it flags IPROG instead of reconfiguring.

---
 rtl/icape2_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_icape2_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/icape2_responder.sv
`default_nettype none
// ============================================================================
//  Module      : icape2_responder
//  Description : Behavioural stand-in for the 7-series ICAPE2 primitive.
//                Decodes the configuration word stream (dummy, sync, NOOP,
//                Type1/Type2 read and write packets, DESYNC) into a 32x32
//                register file and returns readback words. An IPROG command
//                raises a pulse instead of reconfiguring the device.
//
//  Ports       : i_clk     - ICAP clock, rising edge
//                i_reset   - synchronous active-high reset
//                i_csib    - active-low select
//                i_rdwrb   - 1 = read cycle, 0 = write cycle
//                i_data    - config word, bits reversed within each byte
//                o_data    - readback word, bits reversed within each byte
//                o_synced  - sync word seen, no DESYNC since
//                o_iprog   - one-cycle pulse on CMD <= IPROG
//                o_wbstar  - current WBSTAR register contents
//                o_err     - sticky protocol error flag
//
//  Options     : `define ICAP_RESP_TYPE2_EN to accept Type2 packet headers
//                (they reuse the last Type1 address). Without it every
//                Type2 header is flagged as an error and ignored.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module icape2_responder #(
    parameter logic [31:0] IDCODE   = 32'h0362D093,
    parameter int unsigned READ_LAT = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_csib,
    input  logic        i_rdwrb,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_synced,
    output logic        o_iprog,
    output logic [31:0] o_wbstar,
    output logic        o_err
);

    localparam logic [31:0] c_SYNC        = 32'hAA995566;
    localparam logic [31:0] c_DUMMY       = 32'hFFFFFFFF;
    localparam logic [31:0] c_CMD_IPROG   = 32'h0000000F;
    localparam logic [31:0] c_CMD_DESYNC  = 32'h0000000D;
    localparam logic [4:0]  c_ADDR_CMD    = 5'h04;
    localparam logic [4:0]  c_ADDR_STAT   = 5'h07;
    localparam logic [4:0]  c_ADDR_IDCODE = 5'h0C;
    localparam logic [4:0]  c_ADDR_WBSTAR = 5'h10;
    localparam logic [2:0]  c_LAT         = 3'(READ_LAT);

    typedef enum logic [1:0] {
        S_UNSYNC = 2'd0,
        S_HDR    = 2'd1,
        S_WR     = 2'd2,
        S_RD     = 2'd3
    } state_t;

    // The primitive's data pins are bit-reversed inside each byte.
    function automatic logic [31:0] f_swap(input logic [31:0] d);
        logic [31:0] s;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
                s[8*b+k] = d[8*b+7-k];
            end
        end
        return s;
    endfunction

    state_t      r_state;
    logic [31:0] r_regs [0:31];
    logic [4:0]  r_addr;
    logic [26:0] r_count;
    logic [2:0]  r_lat;
    logic        r_lat_started;
    logic        r_rdwrb_q;

    logic [31:0] w_word;
    logic        w_wr;
    logic        w_rd;
    logic        w_abort;
    logic        w_is_t1;
    logic        w_is_t2;
    logic        w_t2_ok;
    logic        w_pkt_ok;
    logic        w_ignore;
    logic [1:0]  w_op;
    logic [26:0] w_pkt_cnt;
    logic [2:0]  w_lat_cur;
    logic [31:0] w_rd_word;

    assign w_word    = f_swap(i_data);
    assign w_wr      = !i_csib && !i_rdwrb;
    assign w_rd      = !i_csib &&  i_rdwrb;
    // Direction may only change while deselected; a change under select is
    // an aborted transfer. Before sync the stream is ignored entirely.
    assign w_abort   = !i_csib && (i_rdwrb != r_rdwrb_q) && (r_state != S_UNSYNC);
    assign w_is_t1   = (w_word[31:29] == 3'b001);
    assign w_is_t2   = (w_word[31:29] == 3'b010);
    assign w_op      = w_word[28:27];
    assign w_pkt_cnt = w_is_t1 ? {16'd0, w_word[10:0]} : w_word[26:0];
    assign w_ignore  = (w_word == c_DUMMY) || (w_word == c_SYNC);
    assign w_pkt_ok  = w_is_t1 || w_t2_ok;
    assign w_lat_cur = r_lat_started ? r_lat : c_LAT;
    assign o_wbstar  = r_regs[c_ADDR_WBSTAR];

`ifdef ICAP_RESP_TYPE2_EN
    logic r_have_t1;

    assign w_t2_ok = w_is_t2 && r_have_t1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_have_t1 <= 1'b0;
        end else if (!w_abort && r_state == S_HDR && w_wr && !w_ignore && w_is_t1) begin
            r_have_t1 <= 1'b1;
        end
    end
`else
    assign w_t2_ok = 1'b0;
`endif

    always_comb begin
        w_rd_word = r_regs[r_addr];
        if (r_addr == c_ADDR_IDCODE) begin
            w_rd_word = IDCODE;
        end else if (r_addr == c_ADDR_STAT) begin
            w_rd_word = {31'd0, o_synced};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_UNSYNC;
            r_addr        <= '0;
            r_count       <= '0;
            r_lat         <= '0;
            r_lat_started <= 1'b0;
            r_rdwrb_q     <= 1'b0;
            o_data        <= '0;
            o_synced      <= 1'b0;
            o_iprog       <= 1'b0;
            o_err         <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            o_iprog   <= 1'b0;
            r_rdwrb_q <= i_rdwrb;
            if (w_abort) begin
                o_err         <= 1'b1;
                r_state       <= S_HDR;
                r_count       <= '0;
                r_lat         <= '0;
                r_lat_started <= 1'b0;
            end else begin
                case (r_state)
                    S_UNSYNC: begin
                        if (w_wr && w_word == c_SYNC) begin
                            r_state  <= S_HDR;
                            o_synced <= 1'b1;
                        end else if (w_rd) begin
                            o_data <= '1;
                        end
                    end
                    S_HDR: begin
                        if (w_wr && !w_ignore) begin
                            if (!w_pkt_ok) begin
                                o_err <= 1'b1;
                            end else begin
                                if (w_is_t1) begin
                                    r_addr <= w_word[17:13];
                                end
                                case (w_op)
                                    2'b01: begin
                                        if (w_pkt_cnt != '0) begin
                                            r_state       <= S_RD;
                                            r_count       <= w_pkt_cnt;
                                            r_lat         <= '0;
                                            r_lat_started <= 1'b0;
                                            o_data        <= '1;
                                        end
                                    end
                                    2'b10: begin
                                        if (w_pkt_cnt != '0) begin
                                            r_state <= S_WR;
                                            r_count <= w_pkt_cnt;
                                        end
                                    end
                                    2'b11:   o_err <= 1'b1;
                                    default: ;
                                endcase
                            end
                        end
                    end
                    S_WR: begin
                        if (w_wr) begin
                            if (r_addr != c_ADDR_IDCODE) begin
                                r_regs[r_addr] <= w_word;
                            end
                            r_count <= r_count - 27'd1;
                            if (r_count == 27'd1) begin
                                r_state <= S_HDR;
                            end
                            if (r_addr == c_ADDR_CMD && w_word == c_CMD_IPROG) begin
                                o_iprog <= 1'b1;
                            end
                            // DESYNC overrides whatever remains of the packet.
                            if (r_addr == c_ADDR_CMD && w_word == c_CMD_DESYNC) begin
                                o_synced <= 1'b0;
                                r_state  <= S_UNSYNC;
                            end
                        end
                    end
                    S_RD: begin
                        // Write cycles here are NOOP padding and are dropped.
                        if (w_rd) begin
                            r_lat_started <= 1'b1;
                            if (w_lat_cur > 3'd1) begin
                                r_lat <= w_lat_cur - 3'd1;
                            end else begin
                                r_lat   <= '0;
                                o_data  <= f_swap(w_rd_word);
                                r_count <= r_count - 27'd1;
                                if (r_count == 27'd1) begin
                                    r_state <= S_HDR;
                                end
                            end
                        end
                    end
                    default: r_state <= S_UNSYNC;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icape2_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icape2_responder
//  Description : Directed self-checking bench for icape2_responder with the
//                default parameters (READ_LAT = 3, default IDCODE).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icape2_responder;

    logic        i_clk;
    logic        i_reset;
    logic        i_csib;
    logic        i_rdwrb;
    logic [31:0] i_data;
    logic [31:0] o_data;
    logic        o_synced;
    logic        o_iprog;
    logic [31:0] o_wbstar;
    logic        o_err;

    int n_checks = 0;
    int n_errors = 0;

    // IDCODE 32'h0362D093 with every byte bit-reversed.
    localparam logic [31:0] c_IDCODE_SW = 32'hC0460BC9;
    localparam logic [31:0] c_NOOP      = 32'h20000000;

    icape2_responder dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_csib   (i_csib),
        .i_rdwrb  (i_rdwrb),
        .i_data   (i_data),
        .o_data   (o_data),
        .o_synced (o_synced),
        .o_iprog  (o_iprog),
        .o_wbstar (o_wbstar),
        .o_err    (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] swp(input logic [31:0] d);
        logic [31:0] s;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
                s[8*b+k] = d[8*b+7-k];
            end
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] w);
        i_csib  = 1'b0;
        i_rdwrb = 1'b0;
        i_data  = swp(w);
        step();
    endtask

    task automatic rd();
        i_csib  = 1'b0;
        i_rdwrb = 1'b1;
        i_data  = 32'h0;
        step();
    endtask

    task automatic idle(input logic rw);
        i_csib  = 1'b1;
        i_rdwrb = rw;
        i_data  = 32'h0;
        step();
    endtask

    initial begin
        i_reset = 1'b1;
        i_csib  = 1'b1;
        i_rdwrb = 1'b0;
        i_data  = 32'h0;
        step();
        step();
        check("rst_data",   o_data,   32'h0);
        check("rst_synced", {31'd0, o_synced}, 32'd0);
        check("rst_iprog",  {31'd0, o_iprog},  32'd0);
        check("rst_wbstar", o_wbstar, 32'h0);
        check("rst_err",    {31'd0, o_err},    32'd0);
        i_reset = 1'b0;

        // Stream without a sync word is ignored.
        wr(32'h30020001);
        wr(32'h12345678);
        check("unsync_wbstar", o_wbstar, 32'h0);
        check("unsync_synced", {31'd0, o_synced}, 32'd0);
        check("unsync_err",    {31'd0, o_err},    32'd0);
        idle(1'b1);
        rd();
        check("unsync_rd", o_data, 32'hFFFFFFFF);
        idle(1'b0);

        // WBSTAR write followed by IPROG.
        wr(32'hFFFFFFFF);
        wr(32'hAA995566);
        check("sync_synced", {31'd0, o_synced}, 32'd1);
        wr(c_NOOP);
        wr(c_NOOP);
        wr(32'h30020001);
        wr(32'h00400000);
        check("wbstar_val", o_wbstar, 32'h00400000);
        wr(c_NOOP);
        check("iprog_idle", {31'd0, o_iprog}, 32'd0);
        wr(32'h30008001);
        wr(32'h0000000F);
        check("iprog_pulse", {31'd0, o_iprog}, 32'd1);
        idle(1'b0);
        check("iprog_end", {31'd0, o_iprog}, 32'd0);
        check("iprog_err", {31'd0, o_err},   32'd0);

        // IDCODE readback with READ_LAT = 3.
        wr(32'hAA995566);
        wr(32'h28018001);
        wr(c_NOOP);
        wr(c_NOOP);
        idle(1'b1);
        check("rd_pre", o_data, 32'hFFFFFFFF);
        rd();
        check("rd_lat0", o_data, 32'hFFFFFFFF);
        rd();
        check("rd_lat1", o_data, 32'hFFFFFFFF);
        rd();
        check("rd_idcode", o_data, c_IDCODE_SW);
        rd();
        check("rd_hold", o_data, c_IDCODE_SW);
        check("rd_err",  {31'd0, o_err}, 32'd0);
        idle(1'b0);
        // Back in HDR: a new write header must decode.
        wr(32'h30020001);
        wr(32'h00400001);
        check("rd_then_hdr", o_wbstar, 32'h00400001);

        // Abort inside a two-word WBSTAR write.
        wr(32'h30020002);
        wr(32'h11111111);
        check("abort_first", o_wbstar, 32'h11111111);
        i_csib  = 1'b0;
        i_rdwrb = 1'b1;
        i_data  = swp(32'h33333333);
        step();
        check("abort_err",    {31'd0, o_err}, 32'd1);
        check("abort_nostore", o_wbstar, 32'h11111111);
        idle(1'b0);
        wr(32'h30020001);
        wr(32'h00500000);
        check("abort_next_hdr", o_wbstar, 32'h00500000);

        // Reset during read latency.
        wr(32'h28020001);
        idle(1'b1);
        rd();
        i_reset = 1'b1;
        rd();
        check("mid_rst_data",   o_data,   32'h0);
        check("mid_rst_synced", {31'd0, o_synced}, 32'd0);
        check("mid_rst_iprog",  {31'd0, o_iprog},  32'd0);
        check("mid_rst_wbstar", o_wbstar, 32'h0);
        check("mid_rst_err",    {31'd0, o_err},    32'd0);
        i_reset = 1'b0;
        rd();
        check("mid_rst_unsync", o_data, 32'hFFFFFFFF);
        idle(1'b0);

        // DESYNC drops sync; later writes are ignored.
        wr(32'hAA995566);
        wr(32'h30020001);
        wr(32'h00400000);
        check("desync_pre_wbstar", o_wbstar, 32'h00400000);
        wr(32'h30008001);
        wr(32'h0000000D);
        check("desync_synced", {31'd0, o_synced}, 32'd0);
        wr(32'h30020001);
        wr(32'hDEADBEEF);
        check("desync_wbstar", o_wbstar, 32'h00400000);
        check("desync_err",    {31'd0, o_err}, 32'd0);

`ifndef ICAP_RESP_TYPE2_EN
        // Type2 header is rejected and HDR is kept.
        wr(32'hAA995566);
        wr(32'h50000001);
        check("t2_err", {31'd0, o_err}, 32'd1);
        wr(32'h30020001);
        wr(32'hCAFEF00D);
        check("t2_stay_hdr", o_wbstar, 32'hCAFEF00D);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
